soft_i_deserializer: RTL and testbench

Fabric-side 1:WIDTH SDR deserializer with word alignment. It is the receive counterpart of the O_SERDES-based serializer example designs. It samples one serial bit per enabled clock, assembles MSB-first words, and emits a valid pulse per word. It locks word boundaries automatically against a repeated training pattern, using internal bit-slips. A manual bit-slip input is also provided. It sits behind the input buffer/I_DELAY in primitive example designs and feeds parallel fabric logic.

---
 rtl/soft_i_deserializer.sv | 123 ++++++++++++
 tb/tb_soft_i_deserializer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/soft_i_deserializer.sv
// soft_i_deserializer: fabric 1:WIDTH SDR deserializer
// with training-pattern word alignment and manual bit-slip.
module soft_i_deserializer #(
  parameter int unsigned WIDTH = 4,
  parameter logic [WIDTH-1:0] ALIGN_PATTERN = 4'b1100,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             d,
  input  logic             en,
  input  logic             align_start,
  input  logic             bitslip,
  output logic [WIDTH-1:0] q,
  output logic             data_valid,
  output logic             aligned,
  output logic             align_fail,
  output logic [4:0]       slip_count
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);
  localparam logic [4:0] SLIP_MAX = 5'(2 * WIDTH);
  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    CHECK,
    LOCKED
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-2:0] sr;
  logic [CW-1:0]    cnt;
  logic             slip_pend;
  logic [3:0]       match_cnt;
  logic [3:0]       match_n;
  logic [4:0]       slip_cnt_n;
  logic             fail_n;
  logic             slip_req;
  logic             word_done;
  logic [WIDTH-1:0] word;

  assign word      = {sr, d};
  assign word_done = en && !slip_pend && (cnt == CNT_MAX);

  always_comb begin
    state_n    = state;
    match_n    = match_cnt;
    slip_cnt_n = slip_count;
    fail_n     = align_fail;
    slip_req   = 1'b0;
    if (align_start) begin
      state_n    = HUNT;
      match_n    = '0;
      slip_cnt_n = '0;
      fail_n     = 1'b0;
    end else begin
      case (state)
        IDLE, LOCKED: slip_req = bitslip;
        HUNT, CHECK: begin
          if (word_done) begin
            if (word == ALIGN_PATTERN) begin
              match_n = (state == HUNT) ? 4'd1
                                        : match_cnt + 4'd1;
              state_n = (match_n >= LOCK_N) ? LOCKED
                                            : CHECK;
            end else if (slip_count < SLIP_MAX) begin
              // shift the boundary and keep hunting
              match_n    = '0;
              slip_req   = 1'b1;
              slip_cnt_n = slip_count + 5'd1;
              state_n    = HUNT;
            end else begin
              match_n = '0;
              fail_n  = 1'b1;
              state_n = IDLE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state      <= IDLE;
      sr         <= '0;
      cnt        <= '0;
      slip_pend  <= 1'b0;
      match_cnt  <= '0;
      q          <= '0;
      data_valid <= 1'b0;
      aligned    <= 1'b0;
      align_fail <= 1'b0;
      slip_count <= '0;
    end else begin
      state      <= state_n;
      match_cnt  <= match_n;
      slip_count <= slip_cnt_n;
      align_fail <= fail_n;
      aligned    <= (state_n == LOCKED);
      data_valid <= word_done;
      if (word_done) q <= word;
      if (en) begin
        sr <= word[WIDTH-2:0];
        // a consumed slip swallows a bit without counting it
        if (!slip_pend) begin
          cnt <= (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
        end
      end
      if (slip_pend) begin
        if (en) slip_pend <= 1'b0;
      end else if (slip_req) begin
        slip_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_soft_i_deserializer.sv
// tb_soft_i_deserializer: directed scenarios plus randomized
// streams checked against a bit-history reference model.
module tb_soft_i_deserializer;

  localparam int W = 4;
  localparam logic [W-1:0] PAT = 4'b1100;
  localparam int LC = 4;

  logic         clk_in = 1'b0;
  logic         reset;
  logic         d;
  logic         en;
  logic         align_start;
  logic         bitslip;
  logic [W-1:0] q;
  logic         data_valid;
  logic         aligned;
  logic         align_fail;
  logic [4:0]   slip_count;

  soft_i_deserializer #(
    .WIDTH(W),
    .ALIGN_PATTERN(PAT),
    .LOCK_COUNT(LC)
  ) dut (
    .clk_in(clk_in),
    .reset(reset),
    .d(d),
    .en(en),
    .align_start(align_start),
    .bitslip(bitslip),
    .q(q),
    .data_valid(data_valid),
    .aligned(aligned),
    .align_fail(align_fail),
    .slip_count(slip_count)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  typedef enum int {MI, MH, MC, ML} mode_t;

  mode_t        m_mode;
  int           m_cnt;
  int           m_mc;
  logic [W-1:0] m_hist;
  bit           m_pend;
  logic [W-1:0] e_q;
  bit           e_dv;
  bit           e_al;
  bit           e_fail;
  int           e_sc;

  task automatic model(bit r, bit dd, bit e, bit as, bit bs);
    bit done;
    bit req;
    bit pend0;
    done  = 0;
    req   = 0;
    pend0 = m_pend;
    e_dv  = 0;
    if (r) begin
      m_mode = MI; m_cnt = 0; m_mc = 0; m_hist = '0;
      m_pend = 0; e_q = '0; e_al = 0; e_fail = 0; e_sc = 0;
      return;
    end
    if (e) begin
      m_hist = {m_hist[W-2:0], dd};
      if (pend0) m_pend = 0;
      else begin
        m_cnt++;
        if (m_cnt == W) begin
          m_cnt = 0; done = 1; e_q = m_hist; e_dv = 1;
        end
      end
    end
    if (as) begin
      m_mode = MH; m_mc = 0; e_sc = 0; e_fail = 0;
    end else begin
      if (bs && (m_mode == MI || m_mode == ML)) req = 1;
      if (done && (m_mode == MH || m_mode == MC)) begin
        if (e_q == PAT) begin
          m_mc = (m_mode == MH) ? 1 : m_mc + 1;
          m_mode = (m_mc >= LC) ? ML : MC;
        end else if (e_sc < 2 * W) begin
          req = 1; e_sc++; m_mc = 0; m_mode = MH;
        end else begin
          e_fail = 1; m_mc = 0; m_mode = MI;
        end
      end
    end
    if (req && !pend0) m_pend = 1;
    e_al = (m_mode == ML);
  endtask

  task automatic step(bit r, bit dd, bit e, bit as, bit bs);
    reset = r; d = dd; en = e; align_start = as; bitslip = bs;
    @(posedge clk_in);
    model(r, dd, e, as, bs);
    #1;
    check("q", 32'(q), 32'(e_q));
    check("data_valid", 32'(data_valid), 32'(e_dv));
    check("aligned", 32'(aligned), 32'(e_al));
    check("align_fail", 32'(align_fail), 32'(e_fail));
    check("slip_count", 32'(slip_count), 32'(e_sc));
  endtask

  function automatic bit pat_bit(int idx);
    logic [W-1:0] p;
    p = PAT;
    return p[W-1 - (idx % W)];
  endfunction

  initial begin
    logic [7:0] basic;
    int ph;
    int idx;
    int kind;
    bit dd;
    bit e;
    basic = 8'b1011_0010;

    step(1, 0, 0, 0, 0);
    check("reset_q", 32'(q), 0);
    check("reset_dv", 32'(data_valid), 0);

    for (int i = 0; i < 8; i++) begin
      step(0, basic[7 - i], 1, 0, 0);
      if (i == 3) check("basic_w0", 32'(q), 32'hb);
      if (i == 7) check("basic_w1", 32'(q), 32'h2);
      if (i == 2) check("basic_novalid", 32'(data_valid), 0);
    end

    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++)
      step(0, pat_bit(i + 1), 1, i == 0, 0);
    check("align_slips", 32'(slip_count), 3);
    check("align_lock", 32'(aligned), 1);
    check("align_q", 32'(q), 32'hc);

    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 60; i++) step(0, 0, 1, i == 0, 0);
    check("fail_flag", 32'(align_fail), 1);
    check("fail_aligned", 32'(aligned), 0);
    check("fail_slips", 32'(slip_count), 8);

    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 24; i++) begin
      step(0, (i % 4) == 0, 1, 0, i == 8);
      if (i == 7) check("mslip_pre", 32'(q), 32'h8);
    end
    check("mslip_post", 32'(q), 32'h1);
    step(0, 0, 1, 1, 1);
    for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 0);

    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    check("gate_early", 32'(data_valid), 0);
    step(0, 1, 1, 0, 0);
    check("gate_valid", 32'(data_valid), 1);
    check("gate_q", 32'(q), 32'hd);

    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 18; i++)
      step(0, pat_bit(i + 1), 1, i == 0, 0);
    step(1, 0, 0, 0, 0);
    check("rst_check_q", 32'(q), 0);
    check("rst_check_sc", 32'(slip_count), 0);
    for (int i = 0; i < 30; i++)
      step(0, pat_bit(i), 1, i == 0, 0);
    check("relock", 32'(aligned), 1);
    step(0, pat_bit(30), 1, 1, 0);
    check("restart_al", 32'(aligned), 0);
    check("restart_sc", 32'(slip_count), 0);
    for (int i = 31; i < 60; i++) step(0, pat_bit(i), 1, 0, 0);
    check("rehunt_lock", 32'(aligned), 1);

    for (int it = 0; it < 20; it++) begin
      step(1, 0, 0, 0, 0);
      ph = $urandom_range(0, 3);
      kind = $urandom_range(0, 3);
      idx = ph;
      for (int c = 0; c < 150; c++) begin
        e = $urandom_range(0, 9) != 0;
        if (kind == 0) dd = $urandom_range(0, 1) == 1;
        else dd = pat_bit(idx) ^ ($urandom_range(0, 59) == 0);
        if (e) idx++;
        step($urandom_range(0, 299) == 0, dd, e,
             (c == 2) || ($urandom_range(0, 199) == 0),
             $urandom_range(0, 29) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
